// File: rtl/bist_pkg.sv
// Shared definitions for the March C- BIST controller: FSM states, element
// indices and the per-element march table.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CHK,
        S_DONE
    } state_t;

    localparam int NUM_ELEMS = 6;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;
    localparam logic [2:0] LAST_ELEM = E5;

    // One row of the march table: sweep direction, op count, and for each op
    // whether it writes and whether its background is all-ones.
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_one;
        logic op1_wr;
        logic op1_one;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
        elem_cfg_t c;
        c = '0;
        case (elem)
            E0: c = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_one: 1'b0, op1_wr: 1'b0, op1_one: 1'b0};
            E1: c = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b1, op1_one: 1'b1};
            E2: c = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b1, op1_wr: 1'b1, op1_one: 1'b0};
            E3: c = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b1, op1_one: 1'b1};
            E4: c = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b1, op1_wr: 1'b1, op1_one: 1'b0};
            E5: c = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b0, op1_one: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/march_bist_ctrl_if.sv
// Memory-side bus between the BIST controller (master) and the single-port
// synchronous memory (slave).
interface march_bist_ctrl_if #(
    parameter int A_WIDTH = 4,
    parameter int WIDTH   = 4
);
    logic               mem_read;
    logic               mem_write;
    logic [A_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for the march sweep; `last` flags the
// terminal address of the current direction.
module march_addr_gen #(
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               load_down,
    input  logic               step,
    input  logic               down,
    output logic [A_WIDTH-1:0] addr,
    output logic               last
);
    localparam logic [A_WIDTH-1:0] ONE = A_WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - ONE : addr + ONE;
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller for a single-port synchronous memory.
// Define BIST_STOP_ON_FAIL_EN to end the test at the first mismatching read.
module march_bist_ctrl
    import bist_pkg::*;
#(
    parameter int A_WIDTH   = 4,
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [A_WIDTH-1:0]   fail_addr,
    output logic [2:0]           fail_elem,
    output logic [CNT_WIDTH-1:0] fail_count,
    march_bist_ctrl_if.master    mem
);

    state_t             state_q, state_d;
    logic [2:0]         elem_q, elem_d;
    logic               op_q, op_d;
    logic               advance;
    logic               issue;
    logic               ag_load, ag_load_down, ag_step, ag_down, ag_last;
    logic [A_WIDTH-1:0] addr;
    logic [WIDTH-1:0]   wdata_q;
    logic               exp_one;
    logic               next_one;
    logic               mismatch;

    march_addr_gen #(.A_WIDTH(A_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (ag_down),
        .addr      (addr),
        .last      (ag_last)
    );

    assign ag_down      = elem_cfg(elem_q).down;
    assign ag_load_down = elem_cfg(elem_d).down;
    assign exp_one      = op_q ? elem_cfg(elem_q).op1_one : elem_cfg(elem_q).op0_one;
    assign next_one     = op_d ? elem_cfg(elem_d).op1_one : elem_cfg(elem_d).op0_one;
    assign mismatch     = (state_q == S_CHK) && (mem.mem_rdata != {WIDTH{exp_one}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= E0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        advance = 1'b0;
        issue   = 1'b0;
        ag_load = 1'b0;
        ag_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    elem_d  = E0;
                    op_d    = 1'b0;
                    ag_load = 1'b1;
                    issue   = 1'b1;
                end
            end
            S_WR:  advance = 1'b1;
            S_RD:  state_d = S_CHK;
            S_CHK: begin
`ifdef BIST_STOP_ON_FAIL_EN
                if (mismatch) state_d = S_DONE;
                else          advance = 1'b1;
`else
                advance = 1'b1;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Next op: second op at this address, else next address, else next element.
        if (advance) begin
            if (!op_q && elem_cfg(elem_q).two_ops) begin
                op_d  = 1'b1;
                issue = 1'b1;
            end else if (!ag_last) begin
                op_d    = 1'b0;
                ag_step = 1'b1;
                issue   = 1'b1;
            end else if (elem_q == LAST_ELEM) begin
                state_d = S_DONE;
            end else begin
                elem_d  = elem_q + 3'd1;
                op_d    = 1'b0;
                ag_load = 1'b1;
                issue   = 1'b1;
            end
        end

        if (issue) begin
            state_d = (op_d ? elem_cfg(elem_d).op1_wr : elem_cfg(elem_d).op0_wr) ? S_WR : S_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q    <= '0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else begin
            if (issue && (state_d == S_WR)) begin
                wdata_q <= {WIDTH{next_one}};
            end
            if ((state_q == S_IDLE) && start) begin
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_elem  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= addr;
                    fail_elem <= elem_q;
                end
                if (!(&fail_count)) begin
                    fail_count <= fail_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign busy          = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CHK);
    assign done          = (state_q == S_DONE);
    assign mem.mem_read  = (state_q == S_RD);
    assign mem.mem_write = (state_q == S_WR);
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: behavioural faulty memory plus a loop-based
// March C- reference that predicts the bus trace and the fail results.
module tb_march_bist_ctrl;

    localparam int A_WIDTH   = 4;
    localparam int WIDTH     = 4;
    localparam int CNT_WIDTH = 8;
    localparam int N         = 1 << A_WIDTH;

    typedef enum int { F_NONE, F_STUCK1, F_COUPLE } fault_t;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [A_WIDTH-1:0] addr;
        logic [WIDTH-1:0]   wdata;
    } op_t;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 start = 1'b0;
    logic                 busy, done, fail;
    logic [A_WIDTH-1:0]   fail_addr;
    logic [2:0]           fail_elem;
    logic [CNT_WIDTH-1:0] fail_count;

    int n_assert = 0;
    int n_fail   = 0;

    march_bist_ctrl_if #(.A_WIDTH(A_WIDTH), .WIDTH(WIDTH)) mem_if ();

    march_bist_ctrl #(.A_WIDTH(A_WIDTH), .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_count (fail_count),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    // Faulty memory model: registered read data, optional stuck-at-1 bit on
    // read or a coupling fault where writing all-ones to the aggressor sets
    // the victim to all-ones.
    fault_t             fault      = F_NONE;
    logic [A_WIDTH-1:0] f_addr     = '0;
    logic [WIDTH-1:0]   stuck_mask = '0;
    logic [A_WIDTH-1:0] f_aggr     = '0;
    logic [A_WIDTH-1:0] f_victim   = '0;
    logic [WIDTH-1:0]   mem_arr [N];
    logic [WIDTH-1:0]   rdata_q    = '0;

    assign mem_if.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (mem_if.mem_write) begin
            mem_arr[mem_if.mem_addr] <= mem_if.mem_wdata;
            if (fault == F_COUPLE && mem_if.mem_addr == f_aggr && mem_if.mem_wdata == '1)
                mem_arr[f_victim] <= '1;
        end
        if (mem_if.mem_read) begin
            rdata_q <= mem_arr[mem_if.mem_addr] |
                       ((fault == F_STUCK1 && mem_if.mem_addr == f_addr) ? stuck_mask : '0);
        end
    end

    // March C- written the way it appears on paper.
    string march_ops [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    bit    march_desc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    op_t                  exp_trace[$];
    logic                 exp_fail;
    logic [A_WIDTH-1:0]   exp_faddr;
    logic [2:0]           exp_felem;
    logic [CNT_WIDTH-1:0] exp_fcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {busy, done, fail, fail_addr, fail_elem, fail_count,
                    mem_if.mem_read, mem_if.mem_write, mem_if.mem_addr, mem_if.mem_wdata}, 32'd0);
    endtask

    task automatic build_ref();
        logic [WIDTH-1:0] m [N];
        bit stop;
        stop = 1'b0;
        exp_trace.delete();
        exp_fail  = 1'b0;
        exp_faddr = '0;
        exp_felem = '0;
        exp_fcnt  = '0;
        for (int a = 0; a < N; a++) m[a] = '0;
        for (int e = 0; e < 6 && !stop; e++) begin
            string s;
            s = march_ops[e];
            for (int k = 0; k < N && !stop; k++) begin
                logic [A_WIDTH-1:0] a;
                a = march_desc[e] ? A_WIDTH'(N - 1 - k) : A_WIDTH'(k);
                for (int o = 0; o < s.len() / 2 && !stop; o++) begin
                    byte              kind;
                    logic [WIDTH-1:0] bg;
                    logic [WIDTH-1:0] rdv;
                    kind = s[2*o];
                    bg   = (s[2*o+1] == "1") ? '1 : '0;
                    if (kind == "w") begin
                        exp_trace.push_back('{rd: 1'b0, wr: 1'b1, addr: a, wdata: bg});
                        m[a] = bg;
                        if (fault == F_COUPLE && a == f_aggr && bg == '1) m[f_victim] = '1;
                    end else begin
                        exp_trace.push_back('{rd: 1'b1, wr: 1'b0, addr: a, wdata: '0});
                        exp_trace.push_back('{rd: 1'b0, wr: 1'b0, addr: a, wdata: '0});
                        rdv = m[a] | ((fault == F_STUCK1 && a == f_addr) ? stuck_mask : '0);
                        if (rdv != bg) begin
                            if (!exp_fail) begin
                                exp_faddr = a;
                                exp_felem = 3'(e);
                            end
                            exp_fail = 1'b1;
                            if (exp_fcnt != '1) exp_fcnt = exp_fcnt + 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
                            stop = 1'b1;
`endif
                        end
                    end
                end
            end
        end
    endtask

    // One start pulse and a cycle-by-cycle comparison against the reference
    // trace. repulse_at / reset_at are trace cycle indices (-1 = unused).
    task automatic run_march(input string name, input int repulse_at, input int reset_at,
                             input bit start_in_done);
        int n;
        build_ref();
        n = exp_trace.size();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ".start_clear"}, {fail, fail_addr, fail_elem, fail_count}, 32'd0);
        for (int i = 0; i < n; i++) begin
            op_t e;
            if (i > 0) @(negedge clk);
            e = exp_trace[i];
            check($sformatf("%s.bus[%0d]", name, i),
                  {busy, done, mem_if.mem_read, mem_if.mem_write, mem_if.mem_addr},
                  {1'b1, 1'b0, e.rd, e.wr, e.addr});
            if (e.wr) check($sformatf("%s.wdata[%0d]", name, i), mem_if.mem_wdata, e.wdata);
            start = (i == repulse_at);
            if (i == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero({name, ".mid_reset"});
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
        start = start_in_done;
        check({name, ".done_cycle"}, {busy, done, mem_if.mem_read, mem_if.mem_write}, 4'b0100);
        check({name, ".fail"},       fail,       exp_fail);
        check({name, ".fail_addr"},  fail_addr,  exp_faddr);
        check({name, ".fail_elem"},  fail_elem,  exp_felem);
        check({name, ".fail_count"}, fail_count, exp_fcnt);
        @(negedge clk);
        start = 1'b0;
        check({name, ".idle_after"}, {busy, done, mem_if.mem_read, mem_if.mem_write}, 4'b0000);
    endtask

    task automatic set_random_fault();
        if ($urandom_range(0, 1) == 0) begin
            fault      = F_STUCK1;
            f_addr     = A_WIDTH'($urandom_range(0, N - 1));
            stuck_mask = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        end else begin
            fault    = F_COUPLE;
            f_aggr   = A_WIDTH'($urandom_range(0, N - 1));
            f_victim = f_aggr + A_WIDTH'($urandom_range(1, N - 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        fault = F_NONE;
        run_march("clean", -1, -1, 1'b1);

        fault = F_STUCK1; f_addr = 4'd5; stuck_mask = 4'b0001;
        run_march("stuck5", -1, -1, 1'b0);

        fault = F_COUPLE; f_aggr = 4'd3; f_victim = 4'd4;
        run_march("couple34", -1, -1, 1'b0);

        fault = F_NONE;
        run_march("repulse", 50, -1, 1'b0);

        fault = F_STUCK1; f_addr = 4'd9; stuck_mask = 4'b1000;
        run_march("reset100", -1, 100, 1'b0);
        fault = F_NONE;
        run_march("after_reset", -1, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            set_random_fault();
            run_march($sformatf("rand%0d", r), -1, -1, 1'b0);
        end

        fault = F_NONE;
        run_march("clean_final", -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
